// File: rtl/bit_stream_deframer.sv
// Serial-to-parallel deframer: hunts for SYNC, then rebuilds FRAME_WORDS words onto a valid/ready port.
// Optional even-parity bit per word when BIT_STREAM_DEFRAMER_PARITY_EN is defined.
module bit_stream_deframer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC        = 8'hA5,
  parameter int               FRAME_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             locked,
  output logic             overflow,
  output logic             parity_err
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(WIDTH);
  localparam int CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

`ifdef BIT_STREAM_DEFRAMER_PARITY_EN
  typedef enum logic [1:0] {HUNT, DATA, PAR} state_t;
`else
  typedef enum logic [0:0] {HUNT, DATA} state_t;
`endif

  state_t           state, next_state;
  logic [WIDTH-1:0] window, shreg;
  logic [FW-1:0]    fill_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    word_cnt;

  logic [WIDTH-1:0] shifted_win, shifted_reg, new_word;
  logic             match, deliver, frame_end;
`ifdef BIT_STREAM_DEFRAMER_PARITY_EN
  logic             new_par;
`endif

  assign shifted_win = {window[WIDTH-2:0], bit_in};
  assign shifted_reg = {shreg[WIDTH-2:0], bit_in};
  assign locked      = (state != HUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    next_state = state;
    match      = 1'b0;
    deliver    = 1'b0;
    frame_end  = 1'b0;
    new_word   = '0;
`ifdef BIT_STREAM_DEFRAMER_PARITY_EN
    new_par    = 1'b0;
`endif
    case (state)
      HUNT: begin
        // The fill check keeps a reset-valued window from matching an all-zero SYNC.
        if (bit_en && shifted_win == SYNC && fill_cnt >= FW'(WIDTH - 1)) begin
          match      = 1'b1;
          next_state = DATA;
        end
      end
      DATA: begin
        if (bit_en && bit_cnt == BW'(WIDTH - 1)) begin
`ifdef BIT_STREAM_DEFRAMER_PARITY_EN
          next_state = PAR;
`else
          deliver    = 1'b1;
          new_word   = shifted_reg;
`endif
        end
      end
`ifdef BIT_STREAM_DEFRAMER_PARITY_EN
      PAR: begin
        if (bit_en) begin
          deliver    = 1'b1;
          new_word   = shreg;
          new_par    = ^{shreg, bit_in};
          next_state = DATA;
        end
      end
`endif
      default: next_state = HUNT;
    endcase
    if (deliver && word_cnt == CW'(FRAME_WORDS - 1)) begin
      frame_end  = 1'b1;
      next_state = HUNT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window     <= '0;
      fill_cnt   <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;

      if (state == HUNT && bit_en) begin
        window <= shifted_win;
        if (fill_cnt != FW'(WIDTH)) fill_cnt <= fill_cnt + 1'b1;
      end

      if (match) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end

      if (state == DATA && bit_en) begin
        shreg   <= shifted_reg;
        bit_cnt <= (bit_cnt == BW'(WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
      end

      if (deliver) word_cnt <= frame_end ? '0 : word_cnt + 1'b1;

      if (frame_end) begin
        window   <= '0;
        fill_cnt <= '0;
      end

      // A new word loads only into an empty slot or one being drained this edge.
      if (deliver && (!word_valid || word_ready)) begin
        word_out   <= new_word;
        word_valid <= 1'b1;
      end else begin
        if (deliver)                   overflow   <= 1'b1;
        if (word_valid && word_ready)  word_valid <= 1'b0;
      end
    end
  end

`ifdef BIT_STREAM_DEFRAMER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   parity_err <= 1'b0;
    else if (deliver && (!word_valid || word_ready)) parity_err <= new_par;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bit_stream_deframer.sv
// Self-checking bench for bit_stream_deframer: scoreboard of expected words, popped on each transfer.
module tb_bit_stream_deframer;

  typedef struct packed {
    logic [7:0] w;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, bit_in, bit_en, word_ready;
  logic [7:0] word_out;
  logic       word_valid, locked, overflow, parity_err;

  exp_t sb[$];
  int   rises[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, ovf_cnt = 0, xfer_cnt = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  bit_stream_deframer #(.WIDTH(8), .SYNC(8'hA5), .FRAME_WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_en(bit_en),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .locked(locked), .overflow(overflow), .parity_err(parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: sample away from the active edge; a transfer happens at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (word_valid && !prev_valid) rises.push_back(cyc);
    prev_valid = word_valid;
    if (overflow) ovf_cnt++;
    if (word_valid && word_ready) begin
      xfer_cnt++;
      check("xfer_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("word_out", word_out, e.w);
        check("parity_err", parity_err, e.p);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit sparse);
    bit_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    if (sparse) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit sparse);
    for (int i = 7; i >= 0; i--) send_bit(b[i], sparse);
  endtask

  task automatic push(input logic [7:0] w, input logic p);
    exp_t e;
    e.w = w;
    e.p = p;
    sb.push_back(e);
  endtask

  task automatic clear_stats();
    xfer_cnt = 0;
    ovf_cnt  = 0;
    rises.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  word_valid, 0);
    check({tag, "_word"},   word_out,   0);
    check({tag, "_locked"}, locked,     0);
    check({tag, "_ovf"},    overflow,   0);
    check({tag, "_par"},    parity_err, 0);
  endtask

`ifndef BIT_STREAM_DEFRAMER_PARITY_EN
  task automatic send_frame(input logic [7:0] w0, w1, w2, w3, input bit sparse);
    send_byte(8'hA5, sparse);
    push(w0, 1'b0); send_byte(w0, sparse);
    push(w1, 1'b0); send_byte(w1, sparse);
    push(w2, 1'b0); send_byte(w2, sparse);
    push(w3, 1'b0); send_byte(w3, sparse);
  endtask
`endif

  initial begin
    logic [47:0] stream;
    rst_n = 1'b0; bit_in = 1'b0; bit_en = 1'b0; word_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) tick();
    rst_n = 1'b1;

`ifndef BIT_STREAM_DEFRAMER_PARITY_EN
    // Basic frame with lock boundaries.
    clear_stats();
    word_ready = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(stream_bit(8'hA5, i), 1'b0);
    check("t1_locked_before_8th", locked, 0);
    send_bit(1'b1, 1'b0);
    check("t1_locked_after_8th", locked, 1);
    push(8'h3C, 1'b0); send_byte(8'h3C, 1'b0);
    push(8'h11, 1'b0); send_byte(8'h11, 1'b0);
    push(8'hFF, 1'b0); send_byte(8'hFF, 1'b0);
    check("t1_locked_mid", locked, 1);
    push(8'h00, 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(1'b0, 1'b0);
    check("t1_locked_before_40th", locked, 1);
    send_bit(1'b0, 1'b0);
    check("t1_locked_after_40th", locked, 0);
    check("t1_valid_last", word_valid, 1);
    repeat (3) tick();
    check("t1_sb_empty", sb.size(), 0);
    check("t1_xfers", xfer_cnt, 4);
    check("t1_rises", rises.size(), 4);
    if (rises.size() == 4)
      for (int i = 1; i < 4; i++) check("t1_gap", rises[i] - rises[i-1], 8);

    // Sparse input: bit_en alternates.
    clear_stats();
    send_frame(8'h3C, 8'h11, 8'hFF, 8'h00, 1'b1);
    repeat (3) tick();
    check("t2_sb_empty", sb.size(), 0);
    check("t2_xfers", xfer_cnt, 4);
    check("t2_rises", rises.size(), 4);
    if (rises.size() == 4)
      for (int i = 1; i < 4; i++) check("t2_gap", rises[i] - rises[i-1], 16);

    // Backpressure: first word held, the rest dropped.
    clear_stats();
    word_ready = 1'b0;
    send_byte(8'hA5, 1'b0);
    push(8'h3C, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    repeat (2) tick();
    check("t3_valid_held", word_valid, 1);
    check("t3_word_held", word_out, 8'h3C);
    check("t3_overflows", ovf_cnt, 3);
    check("t3_unlocked", locked, 0);
    word_ready = 1'b1;
    tick();
    check("t3_valid_drained", word_valid, 0);
    check("t3_xfers", xfer_cnt, 1);
    check("t3_sb_empty", sb.size(), 0);

    // Sliding sync: 52 A5 matches at offset 1.
    clear_stats();
    stream = 48'h52A5_3C11_FF00;
    for (int k = 0; k < 4; k++) push(stream[38 - 8*k -: 8], 1'b0);
    for (int p = 0; p < 48; p++) begin
      send_bit(stream[47 - p], 1'b0);
      if (p == 7) check("t4_locked_after_8", locked, 0);
      if (p == 8) check("t4_locked_after_9", locked, 1);
    end
    repeat (3) tick();
    check("t4_sb_empty", sb.size(), 0);
    check("t4_xfers", xfer_cnt, 4);

    // Reset mid-frame with a pending word.
    clear_stats();
    send_byte(8'hA5, 1'b0);
    push(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    tick();
    word_ready = 1'b0;
    send_byte(8'h02, 1'b0);
    check("t5_pending_word", word_out, 8'h02);
    check("t5_pending_valid", word_valid, 1);
    check("t5_locked", locked, 1);
    send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    repeat (2) tick();
    rst_n = 1'b1;
    word_ready = 1'b1;
    clear_stats();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    repeat (3) tick();
    check("t5_sb_empty", sb.size(), 0);
    check("t5_xfers", xfer_cnt, 4);
`else
    // Parity build: each data word carries an even-parity bit.
    clear_stats();
    word_ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    check("t6_locked", locked, 1);
    push(8'h3C, 1'b1); send_byte(8'h3C, 1'b0); send_bit(1'b1, 1'b0);
    check("t6_perr_first", parity_err, 1);
    push(8'h11, 1'b0); send_byte(8'h11, 1'b0); send_bit(1'b0, 1'b0);
    check("t6_perr_second", parity_err, 0);
    push(8'hFF, 1'b0); send_byte(8'hFF, 1'b0); send_bit(1'b0, 1'b0);
    push(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_bit(1'b0, 1'b0);
    check("t6_unlocked", locked, 0);
    repeat (3) tick();
    check("t6_sb_empty", sb.size(), 0);
    check("t6_xfers", xfer_cnt, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic stream_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule

// File: doc/bit_stream_deframer.md
# bit_stream_deframer

Serial-to-parallel deframer that consumes the registered single-bit stream produced by the D flip-flop stage and rebuilds fixed-width words from it. It hunts for a sync word and collects a fixed number of data words after it. Each word is presented on a valid/ready output port. It sits directly downstream of the flip-flop, with its `bit_in` driven from the flip-flop's `Q`.

## Interface
- `WIDTH`, 8: bits per word and per sync pattern.
- `SYNC`, 8'hA5: sync pattern, `WIDTH` bits, MSB first.
- `FRAME_WORDS`, 4: data words per frame after sync, ≥1.
- `clk` input 1: the one clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `bit_in` input 1: serial data; MSB of each word arrives first.
- `bit_en` input 1: qualifier; `bit_in` is consumed only on edges where `bit_en`=1.
- `word_out` output `WIDTH`: assembled data word.
- `word_valid` output 1: `word_out` holds an untransferred word.
- `word_ready` input 1: consumer accepts `word_out`.
- `locked` output 1: sync found; a frame is in progress.
- `overflow` output 1: one-cycle pulse when a completed word is dropped.
- `parity_err` output 1: parity flag that accompanies `word_out`.

## Operation
- States: HUNT, DATA, PAR. PAR exists only with the macro.
- HUNT:
  - Each qualified bit shifts into a `WIDTH`-bit window: window = {window[WIDTH-2:0], bit_in}.
  - A fill counter counts qualified bits since entering HUNT, saturating at `WIDTH`.
  - A match requires the new window value == `SYNC` and ≥`WIDTH` bits received. This prevents a false match on the reset value, for example when `SYNC`=0.
  - On a match: go to DATA, set `locked`, clear the bit counter and word counter.
- DATA:
  - Shift qualified bits into the assembly register.
  - On the `WIDTH`th bit the word is complete. Go to PAR if the macro is defined; otherwise deliver the word.
- PAR: the next qualified bit is the parity bit. Deliver the word with its parity result.
- Delivery:
  - If `word_valid`=0, or `word_valid`=1 and `word_ready`=1 on this edge, load `word_out` and set `word_valid`.
  - Otherwise drop the new word, pulse `overflow`, and leave `word_out` unchanged.
  - Increment the word counter. After word `FRAME_WORDS` (delivered or dropped), return to HUNT, clear `locked`, and clear the window and fill counter.
- Handshake:
  - A transfer occurs on an edge with `word_valid`=1 and `word_ready`=1.
  - `word_out` and `parity_err` stay stable while `word_valid`=1 and `word_ready`=0.
  - `word_valid` clears after a transfer unless a new word loads on the same edge.
- Counters wrap at their terminal count (bit counter at `WIDTH`, word counter at `FRAME_WORDS`). No arithmetic overflow beyond that.

## Timing
- Reset value of every output is 0, asserted asynchronously on `rst_n` low. Registers: state=HUNT, window=0, fill counter=0, bit counter=0, word counter=0.
- Reset release is synchronous to `clk`. The first qualified bit is the first edge with `rst_n`=1 and `bit_en`=1.
- `locked` rises the cycle after the edge that sampled the last sync bit.
- `word_valid` rises the cycle after the edge that sampled the last data bit, or the parity bit when the macro is defined.
- `overflow` is high for exactly one cycle, coincident with the dropped-word edge +1.
- `locked` falls the cycle after the final word of the frame completes.
- Bits may arrive back-to-back (`bit_en` held at 1). There is no dead cycle between frames or words.
- Reset mid-frame: the partial word, the pending output word and lock are all discarded.

## Configuration
- Macro: `BIT_STREAM_DEFRAMER_PARITY_EN`.
- Defined:
  - Each data word is followed by one even-parity bit; the parity over the word plus the parity bit must be 0.
  - `parity_err`=1 is loaded with the word when the check fails.
  - The word is delivered regardless of the parity result.
- Undefined: there is no PAR state and no parity bit. `parity_err` is tied to 0.

## Test plan
Parameters: WIDTH=8, SYNC=8'hA5, FRAME_WORDS=4, macro undefined unless noted.
1. Basic frame: after reset, send bits A5,3C,11,FF,00 with `bit_en`=1 and `word_ready`=1 → `word_valid` pulses 4 times with `word_out`=3C,11,FF,00. `locked` is high from the cycle after the 8th bit to the cycle after the 40th bit.
2. Sparse input: same stream with `bit_en` alternating 1/0 → the same four words, with `word_valid` spaced 16 cycles apart.
3. Backpressure: same stream with `word_ready`=0 throughout → `word_out`=3C held, `overflow` pulses 3 times. Raising `word_ready` gives exactly one transfer of 3C, then `word_valid`=0.
4. Sliding sync: send 52 A5 then data → lock after the 9th bit (offset-1 match). The first word equals bits 10–17 of the stream.
5. Reset mid-frame: assert `rst_n` low after 2 words → all outputs go to 0 immediately. A fresh A5,01,02,03,04 frame then yields 01,02,03,04.
6. Macro defined: send A5, then 3C followed by parity bit 1, then 11 followed by parity bit 0 → 3C is delivered with `parity_err`=1, and 11 is delivered with `parity_err`=0.
